memory_write_controller: RTL and testbench
==========================================

MEMORY_WRITE_CONTROLLER -- requirements
Module: memory_write_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000: consecutive stable cycles before a button level is accepted (benches use 4).
REQ-002 SHALL have parameter STORE_CYCLES, default 2: width in cycles of the store strobe (legal range 1..15).
REQ-003 SHALL have clk  input  1  single system clock; all state rises on posedge clk.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have sw  input  8  raw switch value to be written.
REQ-006 SHALL have btn_store  input  1  raw, asynchronous store button.
REQ-007 SHALL have btn_next  input  1  raw button, address +1.
REQ-008 SHALL have btn_prev  input  1  raw button, address -1.
REQ-009 SHALL have data  output  8  registered write data to the 4-byte memory system.
REQ-010 SHALL have store  output  1  registered write strobe to the memory system.
REQ-011 SHALL have addr  output  2  registered byte address to the memory system.
REQ-012 SHALL have busy  output  1  high whenever the write FSM is not in IDLE.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that changes its accepted level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 A rising edge of an accepted level SHALL produce a one-cycle event; a held button SHALL produce exactly one event.
REQ-015 A clean raw press SHALL yield its event exactly DEBOUNCE_CYCLES+3 cycles after the first clk edge that samples it high.
REQ-016 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD.
REQ-017 IDLE: on a store event, SHALL capture sw into data and go to SETUP; otherwise remain.
REQ-018 SETUP: one cycle, store=0, then STROBE.
REQ-019 STROBE: store=1 for exactly STORE_CYCLES cycles, then HOLD.
REQ-020 HOLD: one cycle, store=0, then IDLE.
REQ-021 data and addr SHALL be stable from the SETUP cycle through the HOLD cycle inclusive, so level-sensitive byte storage downstream sees a clean setup/hold window.
REQ-022 store SHALL be driven directly from a register and never glitch.
REQ-023 In IDLE, a next event SHALL set addr to addr+1 mod 4 (3 wraps to 0), and a prev event SHALL set addr to addr-1 mod 4 (0 wraps to 3).
REQ-024 Simultaneous next and prev events SHALL leave addr unchanged.
REQ-025 A store event in the same cycle as a next or prev event SHALL take precedence; the address event SHALL be dropped and the write SHALL use the old addr.
REQ-026 Store, next and prev events arriving while busy=1 SHALL be discarded, not queued.
REQ-027 sw changes outside IDLE-capture SHALL NOT affect data.

Reset
REQ-028 Reset SHALL immediately force data=8'h00, store=0, addr=2'b00, busy=0, FSM=IDLE, and clear all synchronizers, debounce counters and accepted levels to 0.
REQ-029 Reset asserted mid-STROBE SHALL drop store in the same instant; no partial strobe SHALL resume after release.
REQ-030 A button held through reset release SHALL produce one event after debouncing completes.

Structure
REQ-031 The package memory_ctrl_pkg SHALL hold the FSM state enumeration, the ADDR_W=2 and DATA_W=8 constants, and the default DEBOUNCE_CYCLES and STORE_CYCLES values.
REQ-032 A sub-module button_debouncer (synchronizer, debounce counter, rising-edge pulse) SHALL be instantiated three times.
REQ-033 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES=4, STORE_CYCLES=2)
REQ-034 sw=8'hA5, press btn_store clean -> data=8'hA5 at SETUP, store high for exactly 2 cycles one cycle later, addr=0, busy high for 4 cycles.
REQ-035 Four btn_next presses then one btn_prev press -> addr sequence 1,2,3,0,3.
REQ-036 btn_store bouncing 1-0-1 every 2 cycles for 10 cycles, then held -> exactly one strobe.
REQ-037 btn_next and btn_store events in the same cycle at addr=2 -> write to addr 2, addr remains 2; btn_next pressed during STROBE -> ignored.
REQ-038 Reset asserted in the first STROBE cycle -> store, data and addr all 0 immediately; no store after release.
REQ-039 sw changed from 8'h3C to 8'hFF during STROBE -> data stays 8'h3C through HOLD.

Source files
------------

// File: rtl/memory_ctrl_pkg.sv
// Shared types and constants for the byte-memory write controller.
package memory_ctrl_pkg;
    localparam int ADDR_W               = 2;
    localparam int DATA_W               = 8;
    localparam int DEBOUNCE_CYCLES_DEF  = 100000;
    localparam int STORE_CYCLES_DEF     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wr_state_e;
endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop synchronizer -> debounced level -> one-cycle rising-edge pulse.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level, so any bounce back resets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            pulse   <= level & ~level_d;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/memory_write_controller.sv
// Button-driven writer for a 4-byte memory: address stepping plus a
// SETUP/STROBE/HOLD write cycle with a glitch-free registered strobe.
module memory_write_controller
    import memory_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STORE_CYCLES    = STORE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_store,
    input  logic              btn_next,
    input  logic              btn_prev,
    output logic [DATA_W-1:0] data,
    output logic              store,
    output logic [ADDR_W-1:0] addr,
    output logic              busy
);
    localparam logic [3:0] SC_LAST = 4'(STORE_CYCLES - 1);

    logic ev_store, ev_next, ev_prev;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_store (
        .clk(clk), .reset(reset), .btn(btn_store), .pulse(ev_store));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(clk), .reset(reset), .btn(btn_next), .pulse(ev_next));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk(clk), .reset(reset), .btn(btn_prev), .pulse(ev_prev));

    wr_state_e         state, state_next;
    logic [3:0]        scnt, scnt_next;
    logic [DATA_W-1:0] data_next;
    logic [ADDR_W-1:0] addr_next;
    logic              store_next;

    always_comb begin
        state_next = state;
        scnt_next  = scnt;
        data_next  = data;
        addr_next  = addr;
        case (state)
            IDLE: begin
                // A store wins over address events arriving in the same cycle.
                if (ev_store) begin
                    data_next  = sw;
                    state_next = SETUP;
                end else if (ev_next && !ev_prev) begin
                    addr_next = addr + 1'b1;
                end else if (ev_prev && !ev_next) begin
                    addr_next = addr - 1'b1;
                end
            end
            SETUP: begin
                scnt_next  = '0;
                state_next = STROBE;
            end
            STROBE: begin
                if (scnt == SC_LAST) state_next = HOLD;
                else                 scnt_next  = scnt + 1'b1;
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Registering the decoded next state keeps store free of decode glitches.
        store_next = (state_next == STROBE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            scnt  <= '0;
            data  <= '0;
            addr  <= '0;
            store <= 1'b0;
        end else begin
            state <= state_next;
            scnt  <= scnt_next;
            data  <= data_next;
            addr  <= addr_next;
            store <= store_next;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_memory_write_controller.sv
// Randomized and directed bench; outputs compared every cycle with a window-based reference model.
module tb_memory_write_controller;
    localparam int D = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       btn_store, btn_next, btn_prev;
    logic [7:0] data;
    logic       store;
    logic [1:0] addr;
    logic       busy;

    memory_write_controller #(.DEBOUNCE_CYCLES(D), .STORE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .sw(sw), .btn_store(btn_store),
        .btn_next(btn_next), .btn_prev(btn_prev), .data(data),
        .store(store), .addr(addr), .busy(busy));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference model: a button level flips once the last D synchronized
    // samples (raw taken two edges earlier) all disagree with it; its event is
    // acted on two edges after the flip.
    logic [D+1:0] hist [3];
    logic         lvl  [3];
    logic [1:0]   ep   [3];
    int           edge_n, wr_edge, n_strobes;
    logic [7:0]   m_data;
    logic [1:0]   m_addr;
    logic         store_prev;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '0; lvl[i] = 1'b0; ep[i] = '0;
        end
        edge_n = 0; wr_edge = -100; m_data = 8'h00; m_addr = 2'd0;
    endtask

    task automatic model_edge();
        logic [2:0]   raw;
        logic         evt [3];
        logic [D-1:0] win;
        logic         rise;
        raw = {btn_prev, btn_next, btn_store};
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            hist[i] = {hist[i][D:0], raw[i]};
            evt[i]  = ep[i][1];
            win     = hist[i][D+1:2];
            rise    = !lvl[i] && (&win);
            if (lvl[i] && !(|win)) lvl[i] = 1'b0;
            if (rise) lvl[i] = 1'b1;
            ep[i] = {ep[i][0], rise};
        end
        if (edge_n >= wr_edge + S + 3) begin
            if (evt[0]) begin
                wr_edge = edge_n;
                m_data  = sw;
            end else if (evt[1] && !evt[2]) begin
                m_addr = m_addr + 2'd1;
            end else if (evt[2] && !evt[1]) begin
                m_addr = m_addr - 2'd1;
            end
        end
    endtask

    task automatic check_all();
        chk("busy",  busy,  (edge_n <= wr_edge + S + 1));
        chk("store", store, (edge_n >= wr_edge + 1 && edge_n <= wr_edge + S));
        chk("data",  data,  m_data);
        chk("addr",  addr,  m_addr);
        if (store && !store_prev) n_strobes++;
        store_prev = store;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press(input int idx, input int hold);
        if (idx == 0) btn_store = 1'b1;
        if (idx == 1) btn_next  = 1'b1;
        if (idx == 2) btn_prev  = 1'b1;
        ticks(hold);
        btn_store = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        ticks(D + 8);
    endtask

    initial begin
        int p, rise_e, blen, s0, k;
        int exp_seq [5];
        exp_seq = '{1, 2, 3, 0, 3};
        n_strobes = 0; store_prev = 1'b0;
        reset = 1'b1; sw = 8'h00;
        btn_store = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all();
        reset = 1'b0;
        ticks(3);

        // Clean store of A5: latency, busy length, single strobe at addr 0
        sw = 8'hA5; btn_store = 1'b1;
        p = edge_n + 1; s0 = n_strobes;
        k = 0;
        while (!busy && k < 30) begin tick(); k++; end
        rise_e = edge_n;
        chk("store_latency", rise_e - p, D + 3);
        chk("data_at_setup", data, 8'hA5);
        blen = 0;
        while (busy && blen < 30) begin
            chk("addr_during_write", addr, 2'd0);
            tick(); blen++;
        end
        chk("busy_len", blen, S + 2);
        btn_store = 1'b0;
        ticks(D + 8);
        chk("one_strobe_clean", n_strobes - s0, 1);

        // Address stepping with wrap in both directions
        for (int i = 0; i < 5; i++) begin
            press(i < 4 ? 1 : 2, D + 4);
            chk("addr_seq", addr, exp_seq[i]);
        end

        // Bouncing store button, then held
        s0 = n_strobes;
        for (int i = 0; i < 5; i++) begin
            btn_store = (i % 2 == 0);
            ticks(2);
        end
        press(0, 12);
        chk("one_strobe_bounce", n_strobes - s0, 1);

        // Store beats a same-cycle next; next landing mid-STROBE is dropped
        press(2, D + 4);
        chk("addr_before_collide", addr, 2'd2);
        sw = 8'h77; s0 = n_strobes;
        btn_store = 1'b1; btn_next = 1'b1;
        ticks(D + 8);
        btn_store = 1'b0; btn_next = 1'b0;
        ticks(D + 8);
        chk("collide_addr", addr, 2'd2);
        btn_store = 1'b1;
        ticks(2);
        btn_next = 1'b1;
        k = 0;
        while (!store && k < 30) begin tick(); k++; end
        chk("collide_write_addr", addr, 2'd2);
        ticks(12);
        btn_store = 1'b0; btn_next = 1'b0;
        ticks(D + 8);
        chk("next_in_strobe_ignored", addr, 2'd2);
        chk("two_strobes", n_strobes - s0, 2);

        // sw changes during STROBE must not reach data
        sw = 8'h3C; btn_store = 1'b1;
        k = 0;
        while (!store && k < 30) begin tick(); k++; end
        chk("store_seen_3c", store, 1'b1);
        sw = 8'hFF;
        k = 0;
        while (busy && k < 30) begin
            chk("data_hold_3c", data, 8'h3C);
            tick(); k++;
        end
        btn_store = 1'b0;
        ticks(D + 8);

        // Reset in the first STROBE cycle
        sw = 8'h5A; btn_store = 1'b1; s0 = n_strobes;
        k = 0;
        while (!store && k < 30) begin tick(); k++; end
        chk("store_before_reset", store, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_store", store, 1'b0);
        chk("rst_data",  data,  8'h00);
        chk("rst_addr",  addr,  2'd0);
        chk("rst_busy",  busy,  1'b0);
        model_reset();
        store_prev = 1'b0; s0 = n_strobes;
        @(negedge clk);
        btn_store = 1'b0;
        ticks(2);
        reset = 1'b0;
        ticks(20);
        chk("no_store_after_reset", n_strobes - s0, 0);

        // Button held through reset release gives exactly one event
        reset = 1'b1; btn_next = 1'b1;
        #1;
        model_reset();
        ticks(3);
        reset = 1'b0;
        ticks(20);
        btn_next = 1'b0;
        ticks(D + 8);
        chk("held_through_reset", addr, 2'd1);

        // Random bouncing on all buttons, fast then slow toggling
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 2500; c++) begin
                sw = 8'($urandom);
                if ($urandom_range(0, ph ? 11 : 5) == 0) btn_store = ~btn_store;
                if ($urandom_range(0, ph ? 9 : 4) == 0)  btn_next  = ~btn_next;
                if ($urandom_range(0, ph ? 9 : 4) == 0)  btn_prev  = ~btn_prev;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
